// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
//   Shared definitions for the parameterised synchronous FIFO:
//     - calc_aw()    : pointer width derived from the FIFO depth
//     - RST_* consts : reset values of the sticky flags and request history
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

    // Pointer width for a power-of-two depth (DEPTH >= 2).
    function automatic int calc_aw(input int depth);
        return $clog2(depth);
    endfunction

    // Sticky error flags come out of reset cleared.
    localparam logic RST_OVERFLOW  = 1'b0;
    localparam logic RST_UNDERFLOW = 1'b0;

    // Request history resets high so a request held through reset is not
    // mistaken for a fresh rising edge when reset releases.
    localparam logic RST_REQ_PREV  = 1'b1;

endpackage

// File: rtl/sync_fifo_param_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_if
//   Bus bundle between the FIFO and whoever drives it.
//   master : drives write data, requests and flag clears; observes status
//   slave  : the FIFO itself
//   Signals:
//     wr_data, wr_request, rd_request,
//     clear_overflow_request, clear_underflow_request   (master -> slave)
//     rd_data, empty, full, almost_empty, almost_full,
//     overflow, underflow, count, wr_index, rd_index     (slave -> master)
// -----------------------------------------------------------------------------
interface sync_fifo_param_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int AW = calc_aw(DEPTH);

    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_request;
    logic                  rd_request;
    logic                  clear_overflow_request;
    logic                  clear_underflow_request;

    logic [DATA_WIDTH-1:0] rd_data;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic                  overflow;
    logic                  underflow;
    logic [AW:0]           count;
    logic [AW-1:0]         wr_index;
    logic [AW-1:0]         rd_index;

    modport master (
        output wr_data, wr_request, rd_request,
               clear_overflow_request, clear_underflow_request,
        input  rd_data, empty, full, almost_empty, almost_full,
               overflow, underflow, count, wr_index, rd_index
    );

    modport slave (
        input  wr_data, wr_request, rd_request,
               clear_overflow_request, clear_underflow_request,
        output rd_data, empty, full, almost_empty, almost_full,
               overflow, underflow, count, wr_index, rd_index
    );

endinterface

// File: rtl/sync_fifo_param_req_edge_detect.sv
// -----------------------------------------------------------------------------
// req_edge_detect
//   Turns a request into an operation strobe.
//     mode = 1 : pulse on the rising edge of a level request (one op per
//                high period, no added latency)
//     mode = 0 : pulse follows the request (one op per high cycle)
//   Ports:
//     clk    in   clock, rising edge
//     reset  in   synchronous, active-high
//     signal in   raw request
//     mode   in   edge (1) / level (0) select
//     pulse  out  effective strobe
// -----------------------------------------------------------------------------
module req_edge_detect
    import sync_fifo_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic signal,
    input  logic mode,
    output logic pulse
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= RST_REQ_PREV;
        end else begin
            r_prev <= signal;
        end
    end

    // Edge detection is combinational against last cycle's sample, so the
    // strobe lands in the same cycle the request first goes high.
    assign pulse = mode ? (signal & ~r_prev) : signal;

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//   Parameterised synchronous FIFO using all DEPTH entries, with occupancy
//   count, almost-full/almost-empty thresholds, simultaneous read/write,
//   sticky overflow/underflow flags and selectable request mode.
//   Parameters:
//     DATA_WIDTH  word width
//     DEPTH       entries (power of two, >= 2)
//     AF_THRESH   almost_full  when count >= AF_THRESH
//     AE_THRESH   almost_empty when count <= AE_THRESH
//     REQ_EDGE    1: requests act on rising edge, 0: act every high cycle
//   Ports:
//     clk    in   clock, rising edge
//     reset  in   synchronous, active-high
//     bus    slave side of sync_fifo_param_if (data, requests, status)
// -----------------------------------------------------------------------------
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter bit REQ_EDGE   = 1'b1
)(
    input  logic               clk,
    input  logic               reset,
    sync_fifo_param_if.slave   bus
);

    localparam int AW = calc_aw(DEPTH);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AF_C    = (AW+1)'(AF_THRESH);
    localparam logic [AW:0]   AE_C    = (AW+1)'(AE_THRESH);
    localparam logic [AW:0]   ONE_C   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_INC = AW'(1);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_index;
    logic [AW-1:0]         r_rd_index;
    logic [AW:0]           r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    // ---------------------------------------------------------------------
    // Request strobes
    // ---------------------------------------------------------------------
    logic w_wr_pulse;
    logic w_rd_pulse;

    req_edge_detect u_wr_req (
        .clk    (clk),
        .reset  (reset),
        .signal (bus.wr_request),
        .mode   (REQ_EDGE),
        .pulse  (w_wr_pulse)
    );

    req_edge_detect u_rd_req (
        .clk    (clk),
        .reset  (reset),
        .signal (bus.rd_request),
        .mode   (REQ_EDGE),
        .pulse  (w_rd_pulse)
    );

    // ---------------------------------------------------------------------
    // Status and operation qualification
    // ---------------------------------------------------------------------
    logic        w_empty;
    logic        w_full;
    logic        w_do_wr;
    logic        w_do_rd;
    logic        w_set_overflow;
    logic        w_set_underflow;
    logic [AW:0] w_count_nxt;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);

    // A write into a full FIFO is still accepted when a read frees the head
    // slot in the same cycle. A read of an empty FIFO is never satisfied by
    // a same-cycle write: there is no bypass path.
    assign w_do_wr = w_wr_pulse & (~w_full | w_rd_pulse);
    assign w_do_rd = w_rd_pulse & ~w_empty;

    assign w_set_overflow  = w_wr_pulse & w_full & ~w_rd_pulse;
    assign w_set_underflow = w_rd_pulse & w_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_do_wr && !w_do_rd) begin
            w_count_nxt = r_count + ONE_C;
        end else if (!w_do_wr && w_do_rd) begin
            w_count_nxt = r_count - ONE_C;
        end
    end

    // ---------------------------------------------------------------------
    // Storage: no reset so it maps onto distributed RAM. Writes are held off
    // during reset so a request in the reset cycle leaves no trace.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_do_wr && !reset) begin
            r_mem[r_wr_index] <= bus.wr_data;
        end
    end

    // ---------------------------------------------------------------------
    // Pointers and count. Power-of-two depth lets the pointers wrap
    // naturally from DEPTH-1 to 0.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_index <= '0;
            r_rd_index <= '0;
            r_count    <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_index <= r_wr_index + PTR_INC;
            end
            if (w_do_rd) begin
                r_rd_index <= r_rd_index + PTR_INC;
            end
            r_count <= w_count_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Sticky error flags: a set event outranks a same-cycle clear. Clears
    // have no effect on data movement.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= RST_OVERFLOW;
            r_underflow <= RST_UNDERFLOW;
        end else begin
            if (w_set_overflow) begin
                r_overflow <= 1'b1;
            end else if (bus.clear_overflow_request) begin
                r_overflow <= 1'b0;
            end

            if (w_set_underflow) begin
                r_underflow <= 1'b1;
            end else if (bus.clear_underflow_request) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign bus.rd_data      = r_mem[r_rd_index];
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
    assign bus.almost_full  = (r_count >= AF_C);
    assign bus.almost_empty = (r_count <= AE_C);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
    assign bus.count        = r_count;
    assign bus.wr_index     = r_wr_index;
    assign bus.rd_index     = r_rd_index;

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
//   Directed bench: one FIFO in level mode (REQ_EDGE=0) and one in edge mode
//   (REQ_EDGE=1), both DATA_WIDTH=8, DEPTH=16, sharing clock and reset.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

    logic clk;
    logic reset;

    int n_total;
    int n_pass;

    sync_fifo_param_if #(.DATA_WIDTH(8), .DEPTH(16)) bus_l ();
    sync_fifo_param_if #(.DATA_WIDTH(8), .DEPTH(16)) bus_e ();

    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14),
                      .AE_THRESH(2), .REQ_EDGE(1'b0)) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_l)
    );

    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14),
                      .AE_THRESH(2), .REQ_EDGE(1'b1)) dut_e (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_reset_l(input string tag);
        chk({tag, ".count"},  32'(bus_l.count), 0);
        chk({tag, ".empty"},  32'(bus_l.empty), 1);
        chk({tag, ".full"},   32'(bus_l.full), 0);
        chk({tag, ".ae"},     32'(bus_l.almost_empty), 1);
        chk({tag, ".af"},     32'(bus_l.almost_full), 0);
        chk({tag, ".ovf"},    32'(bus_l.overflow), 0);
        chk({tag, ".udf"},    32'(bus_l.underflow), 0);
        chk({tag, ".wr_idx"}, 32'(bus_l.wr_index), 0);
        chk({tag, ".rd_idx"}, 32'(bus_l.rd_index), 0);
    endtask

    task automatic chk_reset_e(input string tag);
        chk({tag, ".count"},  32'(bus_e.count), 0);
        chk({tag, ".empty"},  32'(bus_e.empty), 1);
        chk({tag, ".full"},   32'(bus_e.full), 0);
        chk({tag, ".ae"},     32'(bus_e.almost_empty), 1);
        chk({tag, ".af"},     32'(bus_e.almost_full), 0);
        chk({tag, ".ovf"},    32'(bus_e.overflow), 0);
        chk({tag, ".udf"},    32'(bus_e.underflow), 0);
        chk({tag, ".wr_idx"}, 32'(bus_e.wr_index), 0);
        chk({tag, ".rd_idx"}, 32'(bus_e.rd_index), 0);
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0;
        n_pass  = 0;

        reset = 1'b1;
        bus_l.wr_data = '0; bus_l.wr_request = 0; bus_l.rd_request = 0;
        bus_l.clear_overflow_request = 0; bus_l.clear_underflow_request = 0;
        bus_e.wr_data = '0; bus_e.wr_request = 0; bus_e.rd_request = 0;
        bus_e.clear_overflow_request = 0; bus_e.clear_underflow_request = 0;
        tick(); tick();
        reset = 1'b0;

        // Reset state of both instances
        chk_reset_l("rst_l");
        chk_reset_e("rst_e");

        // ---- Level mode: fill 0x01..0x10 on consecutive cycles ----
        bus_l.wr_request = 1;
        for (int i = 1; i <= 16; i++) begin
            bus_l.wr_data = 8'(i);
            tick();
            chk($sformatf("fill.count%0d", i), 32'(bus_l.count), 32'(i));
            chk($sformatf("fill.af%0d", i), 32'(bus_l.almost_full), (i >= 14) ? 1 : 0);
            chk($sformatf("fill.ae%0d", i), 32'(bus_l.almost_empty), (i <= 2) ? 1 : 0);
            if (i == 1) chk("fill.fwft", 32'(bus_l.rd_data), 32'h01);
        end
        chk("fill.full",   32'(bus_l.full), 1);
        chk("fill.wr_idx", 32'(bus_l.wr_index), 0);

        // 17th write overflows and is dropped
        bus_l.wr_data = 8'hAA;
        tick();
        chk("ovf.set",    32'(bus_l.overflow), 1);
        chk("ovf.count",  32'(bus_l.count), 16);
        chk("ovf.wr_idx", 32'(bus_l.wr_index), 0);

        // Clear together with another overflowing write: set wins
        bus_l.wr_data = 8'hBB;
        bus_l.clear_overflow_request = 1;
        tick();
        chk("ovfclr.setwins", 32'(bus_l.overflow), 1);
        bus_l.wr_request = 0;
        tick();
        chk("ovfclr.alone", 32'(bus_l.overflow), 0);
        bus_l.clear_overflow_request = 0;

        // Drain: order 0x01..0x10, dropped words never appear
        bus_l.rd_request = 1;
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drain.data%0d", i), 32'(bus_l.rd_data), 32'(i));
            tick();
        end
        bus_l.rd_request = 0;
        chk("drain.empty",  32'(bus_l.empty), 1);
        chk("drain.count",  32'(bus_l.count), 0);
        chk("drain.rd_idx", 32'(bus_l.rd_index), 0);
        chk("drain.udf",    32'(bus_l.underflow), 0);

        // Write + read while empty: write only, underflow set, no bypass
        bus_l.wr_data = 8'h33; bus_l.wr_request = 1; bus_l.rd_request = 1;
        tick();
        bus_l.wr_request = 0; bus_l.rd_request = 0;
        chk("wre.count",  32'(bus_l.count), 1);
        chk("wre.udf",    32'(bus_l.underflow), 1);
        chk("wre.data",   32'(bus_l.rd_data), 32'h33);
        chk("wre.wr_idx", 32'(bus_l.wr_index), 1);
        chk("wre.rd_idx", 32'(bus_l.rd_index), 0);

        bus_l.clear_underflow_request = 1;
        tick();
        bus_l.clear_underflow_request = 0;
        chk("udfclr", 32'(bus_l.underflow), 0);
        chk("udfclr.count", 32'(bus_l.count), 1);

        // Refill to full with 0x41..0x4F
        bus_l.wr_request = 1;
        for (int i = 1; i <= 15; i++) begin
            bus_l.wr_data = 8'(8'h40 + i);
            tick();
        end
        chk("refill.full",   32'(bus_l.full), 1);
        chk("refill.wr_idx", 32'(bus_l.wr_index), 0);

        // Write + read while full: both happen
        bus_l.wr_data = 8'h55; bus_l.rd_request = 1;
        tick();
        bus_l.wr_request = 0; bus_l.rd_request = 0;
        chk("wrf.count",  32'(bus_l.count), 16);
        chk("wrf.ovf",    32'(bus_l.overflow), 0);
        chk("wrf.wr_idx", 32'(bus_l.wr_index), 1);
        chk("wrf.rd_idx", 32'(bus_l.rd_index), 1);
        chk("wrf.head",   32'(bus_l.rd_data), 32'h41);

        // ---- Edge mode: held request gives a single write ----
        bus_e.wr_data = 8'h7E; bus_e.wr_request = 1;
        tick();
        chk("edge.first", 32'(bus_e.count), 1);
        tick(); tick(); tick(); tick();
        chk("edge.held",  32'(bus_e.count), 1);
        chk("edge.data",  32'(bus_e.rd_data), 32'h7E);
        bus_e.wr_request = 0;
        tick();
        chk("edge.low",   32'(bus_e.count), 1);
        bus_e.wr_request = 1;
        tick();
        chk("edge.second", 32'(bus_e.count), 2);
        bus_e.wr_request = 0;
        tick();
        bus_e.wr_request = 1;
        tick();
        chk("edge.third", 32'(bus_e.count), 3);

        // ---- Reset with request held high, then release ----
        reset = 1'b1;
        tick();
        chk_reset_e("rsthold_e");
        tick();
        reset = 1'b0;
        tick(); tick();
        chk_reset_e("rstrel_e");
        chk_reset_l("rstrel_l");

        bus_e.wr_request = 0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
